hex_keypad_entry: RTL and testbench
===================================

HEX_KEYPAD_ENTRY -- requirements
Module: hex_keypad_entry

Interface
REQ-001 Parameter SCAN_DIV_BITS, default 16, width of scan prescaler; one scan tick every 2^SCAN_DIV_BITS clocks.
REQ-002 Parameter DEBOUNCE_TICKS, default 4, consecutive stable scan ticks required for press and for release.
REQ-003 clock  input  1  sole clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 col  input  4  keypad column lines, active-low (pulled up, low = key closed on driven row), asynchronous to clock.
REQ-006 clear  input  1  synchronous, active-high; zeroes num.
REQ-007 row  output  4  keypad row drive, active-low, exactly one bit low at all times.
REQ-008 num  output  16  last four entered hex digits, newest in num[3:0].
REQ-009 key_code  output  4  code of most recently accepted key.
REQ-010 key_valid  output  1  one-clock pulse when a key press is accepted.

Function
REQ-011 col SHALL pass through a two-flop synchronizer before any use; all references to col below mean the synchronized value.
REQ-012 Prescaler SHALL free-run, wrapping from all-ones to 0; scan tick SHALL be asserted in the cycle the prescaler equals all-ones.
REQ-013 Row index r (0..3) SHALL map row = ~(4'b0001 << r); r=0 -> 4'b1110, r=3 -> 4'b0111; r wraps 3 -> 0.
REQ-014 Key code SHALL be {r[1:0], c[1:0]} where c is the index of the single low column bit.
REQ-015 FSM states: SCAN, DEBOUNCE, HELD.
REQ-016 SCAN, on tick: exactly one col bit low -> capture r and c, go DEBOUNCE, debounce count = 1, r unchanged; zero or multiple col bits low -> r advances by 1, stay SCAN.
REQ-017 DEBOUNCE, on tick: col equals captured pattern -> count increments; col differs -> go SCAN, r advances, count cleared.
REQ-018 When DEBOUNCE count reaches DEBOUNCE_TICKS, the same cycle SHALL set key_code, shift num <= {num[11:0], code}, pulse key_valid for that cycle only, go HELD, clear count.
REQ-019 HELD, on tick: col == 4'b1111 -> count increments; otherwise count cleared; r SHALL not change in DEBOUNCE or HELD.
REQ-020 When HELD count reaches DEBOUNCE_TICKS: go SCAN, r advances, count cleared; no key_valid on release.
REQ-021 A held key SHALL produce exactly one key_valid regardless of hold duration (no auto-repeat).
REQ-022 Press latency: key_valid asserts on the DEBOUNCE_TICKS-th tick after the tick that detected the press (the detecting tick counts as 1).
REQ-023 clear SHALL zero num in the cycle it is asserted; if clear and a key acceptance coincide, clear wins for num (num = 0) while key_code and key_valid still update.
REQ-024 num SHALL hold its value between acceptances; digits older than four SHALL be discarded.
REQ-025 Debounce count SHALL saturate logic such that width = clog2(DEBOUNCE_TICKS+1); DEBOUNCE_TICKS = 1 SHALL accept on the detecting tick.

Reset
REQ-026 On reset assertion, immediately: state SCAN, r = 0, row = 4'b1110, prescaler 0, count 0, synchronizer flops 4'b1111, num 16'h0000, key_code 4'h0, key_valid 0.
REQ-027 Reset mid-press SHALL discard the partial press; a key still held after reset release SHALL be re-detected and accepted once.

Structure
REQ-028 Shared package keypad_pkg SHALL hold the FSM state enumeration, the row-drive constant table, and the idle column constant 4'b1111.
REQ-029 Prescaler and tick generation SHALL be one sub-module, keypad_scan_timer (parameter SCAN_DIV_BITS, outputs tick).
REQ-030 All outputs SHALL be registered.

Verification (SCAN_DIV_BITS=4, DEBOUNCE_TICKS=3)
REQ-031 Reset release, no keys -> row sequence 1110,1101,1011,0111,1110 advancing every 16 clocks, key_valid never asserts.
REQ-032 Hold col=4'b1011 whenever row=4'b1101 for 10 ticks -> single key_valid, key_code=4'h6, num=16'h0006, row frozen at 1101 until 3 idle ticks after release.
REQ-033 Enter keys 1,2,3,4,5 (each held then released) -> num=16'h2345 after fifth key_valid.
REQ-034 Press bounce: col low for 1 tick, high for 1 tick -> no key_valid, scan resumes at next row.
REQ-035 Two columns low on one row (4'b0101) -> ignored, no key_valid, row keeps advancing.
REQ-036 Assert clear in same cycle as key_valid for key 4'hA with num=16'h1234 -> num=16'h0000, key_code=4'hA; reset during DEBOUNCE -> outputs at reset values, no key_valid.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the hex keypad entry block: FSM states, row-drive
// table, idle column pattern and column-decode helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    localparam logic [3:0] COL_IDLE = 4'b1111;

    // Active-low row drive indexed by scan row r.
    localparam logic [3:0] ROW_DRIVE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    function automatic logic single_low(input logic [3:0] c);
        return (c == 4'b1110) || (c == 4'b1101) || (c == 4'b1011) || (c == 4'b0111);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] c);
        case (c)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/keypad_scan_timer.sv
// Free-running scan prescaler; tick is high for the one cycle in which the
// prescaler holds all-ones, i.e. once every 2^SCAN_DIV_BITS clocks.
module keypad_scan_timer #(
    parameter int SCAN_DIV_BITS = 16
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    logic [SCAN_DIV_BITS-1:0] prescaler;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + SCAN_DIV_BITS'(1);
        end
    end

    assign tick = &prescaler;

endmodule

// File: rtl/hex_keypad_entry.sv
// 4x4 hex keypad scanner with press/release debounce; accepted keys are
// shifted into a four-digit entry register, newest digit in num[3:0].
module hex_keypad_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_BITS  = 16,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  col,
    input  logic        clear,
    output logic [3:0]  row,
    output logic [15:0] num,
    output logic [3:0]  key_code,
    output logic        key_valid
);

    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_TICKS);

    logic          tick;
    logic [3:0]    col_meta;
    logic [3:0]    col_sync;
    state_t        state, state_next;
    logic [1:0]    r, r_next;
    logic [CW-1:0] cnt, cnt_next, cnt_inc;
    logic [3:0]    cap_col, cap_col_next;
    logic          accept;
    logic [3:0]    accept_code;
    logic [3:0]    row_next;
    logic [15:0]   num_next;
    logic [3:0]    key_code_next;

    keypad_scan_timer #(
        .SCAN_DIV_BITS(SCAN_DIV_BITS)
    ) u_scan_timer (
        .clock(clock),
        .reset(reset),
        .tick (tick)
    );

    // NOTE: sync flops reset to the idle pattern so no phantom key is seen after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_meta <= COL_IDLE;
            col_sync <= COL_IDLE;
        end else begin
            col_meta <= col;
            col_sync <= col_meta;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= SCAN;
            r         <= 2'd0;
            cnt       <= '0;
            cap_col   <= COL_IDLE;
            row       <= ROW_DRIVE[0];
            num       <= 16'h0000;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_next;
            r         <= r_next;
            cnt       <= cnt_next;
            cap_col   <= cap_col_next;
            row       <= row_next;
            num       <= num_next;
            key_code  <= key_code_next;
            key_valid <= accept;
        end
    end

    assign cnt_inc = cnt + CNT_ONE;

    always_comb begin
        state_next   = state;
        r_next       = r;
        cnt_next     = cnt;
        cap_col_next = cap_col;
        accept       = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (single_low(col_sync)) begin
                        cap_col_next = col_sync;
                        if (CNT_ONE == CNT_DONE) begin
                            accept     = 1'b1;
                            state_next = HELD;
                            cnt_next   = '0;
                        end else begin
                            state_next = DEBOUNCE;
                            cnt_next   = CNT_ONE;
                        end
                    end else begin
                        r_next = r + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (col_sync == cap_col) begin
                        if (cnt_inc == CNT_DONE) begin
                            accept     = 1'b1;
                            state_next = HELD;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end else begin
                        state_next = SCAN;
                        r_next     = r + 2'd1;
                        cnt_next   = '0;
                    end
                end
                HELD: begin
                    // Release needs DEBOUNCE_TICKS consecutive idle ticks.
                    if (col_sync == COL_IDLE) begin
                        if (cnt_inc == CNT_DONE) begin
                            state_next = SCAN;
                            r_next     = r + 2'd1;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end else begin
                        cnt_next = '0;
                    end
                end
                default: begin
                    state_next = SCAN;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    assign accept_code = {r, low_index(cap_col_next)};

    always_comb begin
        row_next      = ROW_DRIVE[r_next];
        key_code_next = key_code;
        num_next      = num;
        if (accept) begin
            key_code_next = accept_code;
            num_next      = {num[11:0], accept_code};
        end
        if (clear) begin
            num_next = 16'h0000;
        end
    end

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Self-checking bench for hex_keypad_entry: a behavioural keypad drives col
// from row, and a digit-shift model predicts key_code/num per accepted press.
module tb_hex_keypad_entry;

    localparam int SDB  = 4;
    localparam int DT   = 3;
    localparam int TICK = 1 << SDB;

    logic        clock = 1'b0;
    logic        reset;
    logic        clear;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] num;
    logic [3:0]  key_code;
    logic        key_valid;

    logic        key_dn;
    logic [3:0]  kb_row;
    logic [3:0]  kb_pat;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          valid_seen = 0;
    int          row_bad  = 0;
    logic [15:0] num_model;

    hex_keypad_entry #(
        .SCAN_DIV_BITS (SDB),
        .DEBOUNCE_TICKS(DT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .col      (col),
        .clear    (clear),
        .row      (row),
        .num      (num),
        .key_code (key_code),
        .key_valid(key_valid)
    );

    always #5 clock = ~clock;

    // Physical keypad: the pressed pattern appears only while its row is driven.
    assign col = (key_dn && row == kb_row) ? kb_pat : 4'b1111;

    always @(negedge clock) begin
        if (key_valid === 1'b1) valid_seen++;
        if ($countones(~row) != 1) row_bad++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    function automatic logic [3:0] row_of(input int r);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << r);
    endfunction

    // Wait until the scanner newly arrives on the target row.
    task automatic wait_row_fresh(input logic [3:0] target);
        int n;
        n = 0;
        while (row === target && n < 100) begin step(1); n++; end
        while (row !== target && n < 200) begin step(1); n++; end
        check("row_reached", row, target);
    endtask

    task automatic await_accept(input logic [3:0] code, input int extra,
                                input bit hold_clear, input int exp_lat);
        int v0, n;
        logic [3:0] frozen;
        v0 = valid_seen;
        n  = 0;
        clear = hold_clear;
        while (key_valid !== 1'b1 && n < 400) begin step(1); n++; end
        clear = 1'b0;
        check("accept_seen", 32'(key_valid === 1'b1), 1);
        if (exp_lat >= 0) check("press_latency", n, exp_lat);
        num_model = hold_clear ? 16'h0000 : {num_model[11:0], code};
        check("key_code", key_code, code);
        check("num_after_accept", num, num_model);
        frozen = row;
        step(TICK * (extra + 1));
        check("row_frozen_held", row, frozen);
        check("one_valid_per_press", valid_seen - v0, 1);
        key_dn = 1'b0;
        n = 0;
        while (row === frozen && n < 200) begin step(1); n++; end
        check("release_window", 32'(n >= 33 && n <= 52), 1);
        check("num_holds", num, num_model);
    endtask

    task automatic press_key(input logic [3:0] code, input int extra,
                             input bit hold_clear, input bit timed);
        logic [3:0] r_drive;
        r_drive = row_of(int'(code[3:2]));
        if (timed) wait_row_fresh(r_drive);
        kb_row = r_drive;
        kb_pat = ~(4'b0001 << code[1:0]);
        key_dn = 1'b1;
        await_accept(code, extra, hold_clear, timed ? DT * TICK : -1);
    endtask

    initial begin
        int v0;
        logic [3:0] code;
        reset = 1'b1;
        clear = 1'b0;
        key_dn = 1'b0;
        kb_row = 4'b1111;
        kb_pat = 4'b1111;
        num_model = 16'h0000;
        step(3);
        check("reset_row", row, 4'b1110);
        check("reset_num", num, 16'h0000);
        check("reset_key_code", key_code, 4'h0);
        check("reset_key_valid", key_valid, 1'b0);

        // Idle scan: row advances exactly every TICK clocks after reset release.
        reset = 1'b0;
        step(TICK - 1);
        check("row_before_first_tick", row, 4'b1110);
        step(1);
        check("row_after_first_tick", row, 4'b1101);
        for (int k = 2; k <= 4; k++) begin
            step(TICK);
            check("idle_row_seq", row, row_of(k % 4));
        end
        check("idle_no_valid", valid_seen, 0);

        // Key 6 held for 10 ticks, exact press latency.
        press_key(4'h6, 7, 1'b0, 1'b1);
        check("num_key6", num, 16'h0006);

        // Keys 1..5 in sequence.
        for (int k = 1; k <= 5; k++) press_key(4'(k), 0, 1'b0, 1'b1);
        check("num_12345", num, 16'h2345);

        // Press bounce: one low tick then high.
        v0 = valid_seen;
        wait_row_fresh(4'b1101);
        kb_row = 4'b1101;
        kb_pat = 4'b1011;
        key_dn = 1'b1;
        step(TICK + 4);
        check("bounce_detected_row_frozen", row, 4'b1101);
        key_dn = 1'b0;
        step(TICK);
        check("bounce_resume_next_row", row, 4'b1011);
        check("bounce_no_valid", valid_seen - v0, 0);

        // Two columns low on one row.
        v0 = valid_seen;
        kb_row = 4'b1011;
        kb_pat = 4'b0101;
        wait_row_fresh(4'b1011);
        key_dn = 1'b1;
        step(TICK);
        check("dual_col_row_advances", row, 4'b0111);
        step(3 * TICK);
        check("dual_col_row_wraps", row, 4'b1011);
        step(TICK);
        check("dual_col_row_advances_again", row, 4'b0111);
        key_dn = 1'b0;
        check("dual_col_no_valid", valid_seen - v0, 0);
        check("dual_col_num_kept", num, num_model);

        // Clear coinciding with acceptance of key A.
        for (int k = 1; k <= 4; k++) press_key(4'(k), 0, 1'b0, 1'b0);
        check("num_1234", num, 16'h1234);
        press_key(4'hA, 0, 1'b1, 1'b0);
        check("clear_wins_num", num, 16'h0000);
        check("clear_key_code", key_code, 4'hA);

        // Reset during DEBOUNCE, key still held afterwards.
        press_key(4'h3, 0, 1'b0, 1'b0);
        v0 = valid_seen;
        wait_row_fresh(4'b1011);
        kb_row = 4'b1011;
        kb_pat = 4'b1101;
        key_dn = 1'b1;
        step(TICK + 4);
        check("debounce_row_frozen", row, 4'b1011);
        reset = 1'b1;
        #1;
        check("midpress_reset_row", row, 4'b1110);
        check("midpress_reset_num", num, 16'h0000);
        check("midpress_reset_key_code", key_code, 4'h0);
        check("midpress_reset_key_valid", key_valid, 1'b0);
        step(2);
        check("midpress_no_valid", valid_seen - v0, 0);
        num_model = 16'h0000;
        reset = 1'b0;
        await_accept(4'h9, 1, 1'b0, -1);
        check("redetect_num", num, 16'h0009);

        // Randomized keys, holds, gaps and idle clears.
        for (int i = 0; i < 10; i++) begin
            code = 4'($urandom_range(15));
            if ($urandom_range(3) == 0) begin
                clear = 1'b1;
                step(1);
                clear = 1'b0;
                num_model = 16'h0000;
                check("idle_clear", num, num_model);
            end
            step($urandom_range(40));
            press_key(code, $urandom_range(3), 1'b0, 1'b0);
        end

        check("row_one_hot_low", row_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
